// File: rtl/mem_sweep.sv
// SRAM sweep engine: writes an arithmetic (or constant) pattern over a block of
// addresses, optionally reads it back and counts mismatches against the same pattern.
module mem_sweep #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] baseAddr,
    input  logic [DATA_W-1:0] seed,
    input  logic [DATA_W-1:0] step,
    input  logic [ADDR_W-1:0] count,
    input  logic              showData,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] errCount,
    output logic              errValid,
    output logic [ADDR_W-1:0] firstErrAddr,
    output logic [ADDR_W-1:0] addrBus,
    inout  wire  [DATA_W-1:0] dataBus,
    output logic              memRead,
    output logic              memWrite,
    output logic              memEnable,
    output logic [15:0]       display
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WR_SETUP  = 3'd1,
        S_WR_STROBE = 3'd2,
        S_WR_HOLD   = 3'd3,
        S_RD_STROBE = 3'd4,
        S_RD_CHECK  = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    localparam int WAIT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CYCLES - 1);

    localparam logic [1:0] MODE_WRITE  = 2'b00;
    localparam logic [1:0] MODE_VERIFY = 2'b01;
    localparam logic [1:0] MODE_FILL   = 2'b11;

    state_t w_next_state;
    state_t r_state;

    logic [1:0]        r_mode;
    logic [ADDR_W-1:0] r_base;
    logic [DATA_W-1:0] r_seed;
    logic [DATA_W-1:0] r_step;
    logic [ADDR_W-1:0] r_count;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_pat;
    logic [DATA_W-1:0] r_last_read;
    logic [WAIT_W-1:0] r_wait;
    logic [DATA_W-1:0] r_err_count;
    logic              r_err_valid;
    logic [ADDR_W-1:0] r_first_err;
    logic              r_busy;
    logic              r_done;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_mem_enable;

    logic              w_last;
    logic              w_wait_done;
    logic              w_drive;
    logic              w_mismatch;
    logic [DATA_W-1:0] w_inc;
    logic [15:0]       w_addr16;
    logic [15:0]       w_data16;

    assign w_last      = (r_idx == r_count - ADDR_W'(1));
    assign w_wait_done = (r_wait == WAIT_LAST);
    assign w_inc       = (r_mode == MODE_FILL) ? '0 : r_step;
    assign w_mismatch  = (r_last_read != r_pat);
    // Bus is owned by the engine only while a write word is in progress.
    assign w_drive     = (r_state == S_WR_SETUP) || (r_state == S_WR_STROBE) ||
                         (r_state == S_WR_HOLD);
    assign dataBus     = w_drive ? r_pat : {DATA_W{1'bz}};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (count == '0) begin
                        w_next_state = S_DONE;
                    end else if (mode == MODE_VERIFY) begin
                        w_next_state = S_RD_STROBE;
                    end else begin
                        w_next_state = S_WR_SETUP;
                    end
                end
            end
            S_WR_SETUP: w_next_state = S_WR_STROBE;
            S_WR_STROBE: begin
                if (w_wait_done) begin
                    w_next_state = S_WR_HOLD;
                end
            end
            S_WR_HOLD: begin
                if (!w_last) begin
                    w_next_state = S_WR_SETUP;
                end else if (r_mode == MODE_WRITE) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_RD_STROBE;
                end
            end
            S_RD_STROBE: begin
                if (w_wait_done) begin
                    w_next_state = S_RD_CHECK;
                end
            end
            S_RD_CHECK: w_next_state = w_last ? S_DONE : S_RD_STROBE;
            S_DONE:     w_next_state = S_IDLE;
            default:    w_next_state = S_IDLE;
        endcase
    end

    // Strobes and status are registered from the next state so they line up with r_state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_mem_read   <= 1'b1;
            r_mem_write  <= 1'b1;
            r_mem_enable <= 1'b1;
        end else begin
            r_busy       <= (w_next_state != S_IDLE);
            r_done       <= (w_next_state == S_DONE);
            r_mem_read   <= (w_next_state != S_RD_STROBE);
            r_mem_write  <= (w_next_state != S_WR_STROBE);
            r_mem_enable <= !((w_next_state == S_WR_SETUP) || (w_next_state == S_WR_STROBE) ||
                              (w_next_state == S_WR_HOLD) || (w_next_state == S_RD_STROBE) ||
                              (w_next_state == S_RD_CHECK));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait <= '0;
        end else if (((r_state == S_WR_STROBE) || (r_state == S_RD_STROBE)) &&
                     (w_next_state == r_state)) begin
            r_wait <= r_wait + WAIT_W'(1);
        end else begin
            r_wait <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode      <= 2'b00;
            r_base      <= '0;
            r_seed      <= '0;
            r_step      <= '0;
            r_count     <= '0;
            r_idx       <= '0;
            r_addr      <= '0;
            r_pat       <= '0;
            r_last_read <= '0;
            r_err_count <= '0;
            r_err_valid <= 1'b0;
            r_first_err <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode      <= mode;
                        r_base      <= baseAddr;
                        r_seed      <= seed;
                        r_step      <= step;
                        r_count     <= count;
                        r_idx       <= '0;
                        r_addr      <= baseAddr;
                        r_pat       <= seed;
                        r_err_count <= '0;
                        r_err_valid <= 1'b0;
                        r_first_err <= '0;
                    end
                end
                S_WR_HOLD: begin
                    if (!w_last) begin
                        r_idx  <= r_idx + ADDR_W'(1);
                        r_addr <= r_addr + ADDR_W'(1);
                        r_pat  <= r_pat + w_inc;
                    end else if (r_mode != MODE_WRITE) begin
                        r_idx  <= '0;
                        r_addr <= r_base;
                        r_pat  <= r_seed;
                    end
                end
                S_RD_STROBE: begin
                    if (w_wait_done) begin
                        r_last_read <= dataBus;
                    end
                end
                S_RD_CHECK: begin
                    if (w_mismatch) begin
                        if (r_err_count != '1) begin
                            r_err_count <= r_err_count + DATA_W'(1);
                        end
                        if (!r_err_valid) begin
                            r_err_valid <= 1'b1;
                            r_first_err <= r_addr;
                        end
                    end
                    if (!w_last) begin
                        r_idx  <= r_idx + ADDR_W'(1);
                        r_addr <= r_addr + ADDR_W'(1);
                        r_pat  <= r_pat + w_inc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    generate
        if (ADDR_W >= 16) begin : g_addr_trunc
            assign w_addr16 = r_addr[15:0];
        end else begin : g_addr_ext
            assign w_addr16 = {{(16 - ADDR_W){1'b0}}, r_addr};
        end
        if (DATA_W >= 16) begin : g_data_trunc
            assign w_data16 = r_last_read[15:0];
        end else begin : g_data_ext
            assign w_data16 = {{(16 - DATA_W){1'b0}}, r_last_read};
        end
    endgenerate

    assign display      = showData ? w_data16 : w_addr16;
    assign busy         = r_busy;
    assign done         = r_done;
    assign errCount     = r_err_count;
    assign errValid     = r_err_valid;
    assign firstErrAddr = r_first_err;
    assign addrBus      = r_addr;
    assign memRead      = r_mem_read;
    assign memWrite     = r_mem_write;
    assign memEnable    = r_mem_enable;

endmodule

// File: tb/tb_mem_sweep.sv
// Directed bench for mem_sweep: an ideal SRAM model with an optional stuck-at-zero
// word, strobe bookkeeping, and hand-computed expectations per sweep.
module tb_mem_sweep;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic [15:0] base_addr;
    logic [15:0] seed;
    logic [15:0] step;
    logic [15:0] count;
    logic        show_data;
    logic        busy;
    logic        done;
    logic [15:0] err_count;
    logic        err_valid;
    logic [15:0] first_err_addr;
    logic [15:0] addr_bus;
    wire  [15:0] data_bus;
    logic        mem_read;
    logic        mem_write;
    logic        mem_enable;
    logic [15:0] display;

    logic [15:0] sram [0:65535];
    logic        mem_clear;
    logic        clr_stats;
    logic        fault_en;
    logic [15:0] fault_addr;
    logic [15:0] rd_val;
    int          we_low;
    int          oe_low;
    int          overlap;
    int          checks = 0;
    int          failures = 0;
    int          cyc;

    always #5 clk = ~clk;

    mem_sweep #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .baseAddr(base_addr),
        .seed(seed), .step(step), .count(count), .showData(show_data),
        .busy(busy), .done(done), .errCount(err_count), .errValid(err_valid),
        .firstErrAddr(first_err_addr), .addrBus(addr_bus), .dataBus(data_bus),
        .memRead(mem_read), .memWrite(mem_write), .memEnable(mem_enable),
        .display(display)
    );

    assign rd_val   = (fault_en && addr_bus == fault_addr) ? 16'h0000 : sram[addr_bus];
    assign data_bus = (!mem_enable && !mem_read) ? rd_val : 16'hzzzz;

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 65536; i++) sram[i] <= 16'h0000;
        end else if (!mem_enable && !mem_write) begin
            sram[addr_bus] <= data_bus;
        end
        if (clr_stats) begin
            we_low  <= 0;
            oe_low  <= 0;
            overlap <= 0;
        end else begin
            if (!mem_write) we_low <= we_low + 1;
            if (!mem_read) oe_low <= oe_low + 1;
            if (!mem_write && !mem_read) overlap <= overlap + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_done(inout int c);
        while (!done && c < 2000) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic run_sweep(input logic [1:0] m, input logic [15:0] b, input logic [15:0] sd,
                             input logic [15:0] st, input logic [15:0] n, output int c);
        @(negedge clk);
        clr_stats = 1'b1;
        @(negedge clk);
        clr_stats = 1'b0;
        mode = m; base_addr = b; seed = sd; step = st; count = n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 1;
        wait_done(c);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = 2'b00; base_addr = 16'h0; seed = 16'h0;
        step = 16'h0; count = 16'h0; show_data = 1'b0; mem_clear = 1'b1;
        clr_stats = 1'b1; fault_en = 1'b0; fault_addr = 16'h0103;
        repeat (3) @(negedge clk);
        rst = 1'b0; mem_clear = 1'b0; clr_stats = 1'b0;

        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_errcnt", err_count, 0);
        check("rst_errvalid", err_valid, 0);
        check("rst_firsterr", first_err_addr, 0);
        check("rst_addr", addr_bus, 0);
        check("rst_strobes", {mem_read, mem_write, mem_enable}, 3'b111);
        check("rst_bus_z", data_bus === 16'hzzzz, 1);
        check("rst_display", display, 0);

        // write-only
        run_sweep(2'b00, 16'h0010, 16'h1000, 16'h0001, 16'd4, cyc);
        check("wr_latency", cyc, 13);
        check("wr_m10", sram[16'h0010], 16'h1000);
        check("wr_m11", sram[16'h0011], 16'h1001);
        check("wr_m12", sram[16'h0012], 16'h1002);
        check("wr_m13", sram[16'h0013], 16'h1003);
        check("wr_we_low", we_low, 4);
        check("wr_oe_low", oe_low, 0);
        check("wr_display_addr", display, 16'h0013);

        // write then verify, clean memory
        run_sweep(2'b10, 16'h0100, 16'hAAAA, 16'h0003, 16'd8, cyc);
        check("wv_latency", cyc, 41);
        check("wv_errcnt", err_count, 0);
        check("wv_errvalid", err_valid, 0);
        check("wv_m107", sram[16'h0107], 16'hAABF);
        check("wv_overlap", overlap, 0);
        show_data = 1'b1;
        #1 check("wv_display_data", display, 16'hAABF);
        show_data = 1'b0;

        // write then verify with a stuck-at-zero word
        fault_en = 1'b1;
        run_sweep(2'b10, 16'h0100, 16'hAAAA, 16'h0003, 16'd8, cyc);
        check("flt_errcnt", err_count, 1);
        check("flt_errvalid", err_valid, 1);
        check("flt_firsterr", first_err_addr, 16'h0103);

        // verify-only, same contents
        run_sweep(2'b01, 16'h0100, 16'hAAAA, 16'h0003, 16'd8, cyc);
        check("vo_latency", cyc, 17);
        check("vo_errcnt", err_count, 1);
        check("vo_we_low", we_low, 0);
        check("vo_oe_low", oe_low, 8);

        // verify-only with wrong seed: every word mismatches
        run_sweep(2'b01, 16'h0100, 16'hAAAB, 16'h0003, 16'd8, cyc);
        check("vo_all_errcnt", err_count, 8);
        check("vo_all_firsterr", first_err_addr, 16'h0100);
        fault_en = 1'b0;

        // fill across the address wrap
        run_sweep(2'b11, 16'hFFFE, 16'h5A5A, 16'h1234, 16'd4, cyc);
        check("fill_latency", cyc, 21);
        check("fill_mfffe", sram[16'hFFFE], 16'h5A5A);
        check("fill_mffff", sram[16'hFFFF], 16'h5A5A);
        check("fill_m0000", sram[16'h0000], 16'h5A5A);
        check("fill_m0001", sram[16'h0001], 16'h5A5A);
        check("fill_errcnt", err_count, 0);
        check("fill_errvalid", err_valid, 0);

        // count = 0
        run_sweep(2'b10, 16'h0200, 16'h1111, 16'h0001, 16'd0, cyc);
        check("zero_latency", cyc, 1);
        check("zero_we_low", we_low, 0);
        check("zero_oe_low", oe_low, 0);

        // second start while busy is ignored
        @(negedge clk);
        clr_stats = 1'b1;
        @(negedge clk);
        clr_stats = 1'b0;
        mode = 2'b00; base_addr = 16'h0020; seed = 16'h2000; step = 16'h0001; count = 16'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        check("busy_after_start", busy, 1);
        @(negedge clk);
        cyc = 2;
        base_addr = 16'h0030; seed = 16'h3000; count = 16'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 3;
        wait_done(cyc);
        check("restart_latency", cyc, 13);
        check("restart_m20", sram[16'h0020], 16'h2000);
        check("restart_m23", sram[16'h0023], 16'h2003);
        check("restart_m30", sram[16'h0030], 16'h0000);

        // reset in the third cycle of a sweep
        @(negedge clk);
        mode = 2'b10; base_addr = 16'h0200; seed = 16'h0000; step = 16'h0001; count = 16'd8;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_strobes", {mem_read, mem_write, mem_enable}, 3'b111);
        check("midrst_bus_z", data_bus === 16'hzzzz, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
